// File: rtl/uart_lite_pkg.sv
// Shared constants and state types for the UART Lite AXI4-Lite sequencer.
// Register offsets and STAT bits follow the AXI UART Lite register map.
package uart_lite_pkg;

    localparam logic [3:0] REG_RX   = 4'h0;
    localparam logic [3:0] REG_TX   = 4'h4;
    localparam logic [3:0] REG_STAT = 4'h8;
    localparam logic [3:0] REG_CTRL = 4'hC;

    localparam int STAT_RX_VALID = 0;
    localparam int STAT_TX_EMPTY = 2;
    localparam int STAT_TX_FULL  = 3;
    localparam int STAT_OVERRUN  = 5;
    localparam int STAT_FRAME    = 6;
    localparam int STAT_PARITY   = 7;

    localparam logic [7:0] CTRL_RST_TX_FIFO = 8'h01;
    localparam logic [7:0] CTRL_RST_RX_FIFO = 8'h02;
    localparam logic [7:0] CTRL_INTR_EN     = 8'h10;
    localparam logic [7:0] CTRL_INIT_DEFAULT = CTRL_RST_TX_FIFO | CTRL_RST_RX_FIFO | CTRL_INTR_EN;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_WR_CTRL,
        ST_IDLE,
        ST_RD_STAT,
        ST_RD_RX,
        ST_WR_TX
    } ctrl_state_t;

    typedef enum logic [2:0] {
        AX_IDLE,
        AX_WRITE,
        AX_WRESP,
        AX_RADDR,
        AX_RDATA
    } axi_state_t;

endpackage

// File: rtl/axil_single_master.sv
// AXI4-Lite master with a single outstanding read or write.
// done/rdata/resp_err are valid in the cycle of the final B or R handshake.
module axil_single_master
    import uart_lite_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic        idle,
    output logic        done,
    output logic [31:0] rdata,
    output logic        resp_err,
    output logic [3:0]  m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [3:0]  m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    axi_state_t  state_reg, state_next;
    logic        awvalid_reg, awvalid_next;
    logic        wvalid_reg, wvalid_next;
    logic        bready_reg, bready_next;
    logic        arvalid_reg, arvalid_next;
    logic        rready_reg, rready_next;
    logic [3:0]  awaddr_reg, awaddr_next;
    logic [3:0]  araddr_reg, araddr_next;
    logic [31:0] wdata_reg, wdata_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= AX_IDLE;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b0;
            awaddr_reg  <= '0;
            araddr_reg  <= '0;
            wdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            awvalid_reg <= awvalid_next;
            wvalid_reg  <= wvalid_next;
            bready_reg  <= bready_next;
            arvalid_reg <= arvalid_next;
            rready_reg  <= rready_next;
            awaddr_reg  <= awaddr_next;
            araddr_reg  <= araddr_next;
            wdata_reg   <= wdata_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        awvalid_next = awvalid_reg;
        wvalid_next  = wvalid_reg;
        bready_next  = bready_reg;
        arvalid_next = arvalid_reg;
        rready_next  = rready_reg;
        awaddr_next  = awaddr_reg;
        araddr_next  = araddr_reg;
        wdata_next   = wdata_reg;
        done         = 1'b0;
        resp_err     = 1'b0;
        case (state_reg)
            AX_IDLE: begin
                if (start) begin
                    if (we) begin
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                        awaddr_next  = addr;
                        wdata_next   = wdata;
                        state_next   = AX_WRITE;
                    end else begin
                        arvalid_next = 1'b1;
                        araddr_next  = addr;
                        state_next   = AX_RADDR;
                    end
                end
            end
            AX_WRITE: begin
                // AW and W complete independently; B is only accepted once both are done
                if (m_axi_awready) awvalid_next = 1'b0;
                if (m_axi_wready)  wvalid_next  = 1'b0;
                if (!awvalid_next && !wvalid_next) begin
                    bready_next = 1'b1;
                    state_next  = AX_WRESP;
                end
            end
            AX_WRESP: begin
                if (m_axi_bvalid) begin
                    bready_next = 1'b0;
                    done        = 1'b1;
                    resp_err    = (m_axi_bresp != RESP_OKAY);
                    state_next  = AX_IDLE;
                end
            end
            AX_RADDR: begin
                if (m_axi_arready) begin
                    arvalid_next = 1'b0;
                    rready_next  = 1'b1;
                    state_next   = AX_RDATA;
                end
            end
            AX_RDATA: begin
                if (m_axi_rvalid) begin
                    rready_next = 1'b0;
                    done        = 1'b1;
                    resp_err    = (m_axi_rresp != RESP_OKAY);
                    state_next  = AX_IDLE;
                end
            end
            default: state_next = AX_IDLE;
        endcase
    end

    assign idle          = (state_reg == AX_IDLE);
    assign rdata         = m_axi_rdata;
    assign m_axi_awaddr  = awaddr_reg;
    assign m_axi_awvalid = awvalid_reg;
    assign m_axi_wdata   = wdata_reg;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = wvalid_reg;
    assign m_axi_bready  = bready_reg;
    assign m_axi_araddr  = araddr_reg;
    assign m_axi_arvalid = arvalid_reg;
    assign m_axi_rready  = rready_reg;

endmodule

// File: rtl/uart_lite_ctrl.sv
// Sequences one AXI UART Lite: CTRL init after reset, then STAT-driven
// RX draining and TX writes with round-robin arbitration between them.
module uart_lite_ctrl
    import uart_lite_pkg::*;
#(
    parameter int         POLL_CYCLES = 1024,
    parameter logic [7:0] CTRL_INIT   = CTRL_INIT_DEFAULT
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic        interrupt,
    output logic [3:0]  m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [3:0]  m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [3:0]  err,
    input  logic        err_clr
);

    localparam int              PW          = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [PW-1:0]   POLL_RELOAD = PW'(POLL_CYCLES - 1);

    ctrl_state_t    state_reg, state_next;
    logic [PW-1:0]  poll_reg, poll_next;
    logic [7:0]     rx_data_reg, rx_data_next;
    logic           rx_valid_reg, rx_valid_next;
    logic [3:0]     err_reg, err_next;
    logic           last_rx_reg, last_rx_next;

    logic           m_start, m_we, m_idle, m_done, m_resp_err;
    logic [3:0]     m_addr;
    logic [31:0]    m_wdata, m_rdata;
    logic           rx_cand, tx_cand;
    logic           unused_rdata;

    axil_single_master u_master (
        .clk           (s_axi_aclk),
        .rst_n         (s_axi_aresetn),
        .start         (m_start),
        .we            (m_we),
        .addr          (m_addr),
        .wdata         (m_wdata),
        .idle          (m_idle),
        .done          (m_done),
        .rdata         (m_rdata),
        .resp_err      (m_resp_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_reg    <= ST_INIT;
            poll_reg     <= POLL_RELOAD;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            err_reg      <= '0;
            last_rx_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            poll_reg     <= poll_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            err_reg      <= err_next;
            last_rx_reg  <= last_rx_next;
        end
    end

    assign rx_cand      = m_rdata[STAT_RX_VALID] && !rx_valid_reg;
    assign tx_cand      = !m_rdata[STAT_TX_FULL] && tx_valid;
    assign unused_rdata = ^{m_rdata[31:8], m_rdata[4], m_rdata[STAT_TX_EMPTY], m_rdata[1]};

    always_comb begin
        state_next    = state_reg;
        poll_next     = poll_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = rx_valid_reg;
        last_rx_next  = last_rx_reg;
        err_next      = err_clr ? 4'h0 : err_reg;
        m_start       = 1'b0;
        m_we          = 1'b0;
        m_addr        = REG_STAT;
        m_wdata       = '0;
        tx_ready      = 1'b0;

        if (rx_valid_reg && rx_ready) rx_valid_next = 1'b0;
        // error sets are applied after the clear so a same-cycle set wins
        if (m_done && m_resp_err) err_next[3] = 1'b1;

        case (state_reg)
            ST_INIT: state_next = ST_WR_CTRL;
            ST_WR_CTRL: begin
                m_start = m_idle;
                m_we    = 1'b1;
                m_addr  = REG_CTRL;
                m_wdata = {24'h0, CTRL_INIT};
                if (m_done) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (interrupt || (poll_reg == '0) || tx_valid) begin
                    state_next = ST_RD_STAT;
                    poll_next  = POLL_RELOAD;
                end else begin
                    poll_next = poll_reg - 1'b1;
                end
            end
            ST_RD_STAT: begin
                m_start = m_idle;
                m_addr  = REG_STAT;
                if (m_done) begin
                    err_next[2:0] = err_next[2:0] |
                        {m_rdata[STAT_PARITY], m_rdata[STAT_FRAME], m_rdata[STAT_OVERRUN]};
                    // RX wins a tie unless it was the side served last
                    if (rx_cand && (!tx_cand || !last_rx_reg)) begin
                        state_next   = ST_RD_RX;
                        last_rx_next = 1'b1;
                    end else if (tx_cand) begin
                        state_next   = ST_WR_TX;
                        last_rx_next = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_RD_RX: begin
                m_start = m_idle;
                m_addr  = REG_RX;
                if (m_done) begin
                    rx_data_next  = m_rdata[7:0];
                    rx_valid_next = 1'b1;
                    state_next    = ST_RD_STAT;
                    poll_next     = POLL_RELOAD;
                end
            end
            ST_WR_TX: begin
                m_start = m_idle;
                m_we    = 1'b1;
                m_addr  = REG_TX;
                m_wdata = {24'h0, tx_data};
                if (m_done) begin
                    tx_ready   = 1'b1;
                    state_next = ST_RD_STAT;
                    poll_next  = POLL_RELOAD;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign rx_data  = rx_data_reg;
    assign rx_valid = rx_valid_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_uart_lite_ctrl.sv
// Directed bench for uart_lite_ctrl with a behavioural AXI UART Lite slave.
module tb_uart_lite_ctrl;
    localparam int P = 16;

    typedef struct {
        bit          we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        interrupt;
    logic [3:0]  awaddr, araddr, wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [1:0]  bresp, rresp;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, err_clr;
    logic [3:0]  err;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    // bench-side knobs (written only by the stimulus block)
    int   aw_delay = 0;
    logic ar_stall = 1'b0;
    logic [31:0] stat_default = 32'h4;
    logic [31:0] rx_byte = 32'h0;
    int   rresp_req = 0;
    int   tx_reqs = 0;
    logic [7:0] tx_base = 8'h0;
    logic [31:0] stat_q[$];
    // slave-side state
    txn_t log_q[$];
    int   aw_cnt, rresp_done;
    logic [3:0]  aw_addr_l, last_araddr;
    logic [31:0] w_data_l;
    logic [3:0]  w_strb_l;
    // monitor state
    int   tx_sent = 0;
    int   txr_cnt = 0;
    int   txr_nob = 0;
    int   aw_hi = 0;
    int   w_hi = 0;
    int   overlap = 0;

    assign tx_valid = (tx_sent < tx_reqs);
    assign tx_data  = tx_base + 8'(tx_sent);

    uart_lite_ctrl #(.POLL_CYCLES(P), .CTRL_INIT(8'h13)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .interrupt(interrupt),
        .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART Lite slave: responds on the falling edge, handshakes land on the next rising edge
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0;
            aw_cnt = 0;
        end else begin
            if (awready) awready = 1'b0;
            else if (awvalid) begin
                if (aw_cnt >= aw_delay) begin
                    awready = 1'b1; aw_addr_l = awaddr; aw_cnt = 0;
                end else aw_cnt++;
            end
            if (wready) wready = 1'b0;
            else if (wvalid) begin
                wready = 1'b1; w_data_l = wdata; w_strb_l = wstrb;
            end
            if (bvalid) bvalid = 1'b0;
            else if (bready) begin
                bvalid = 1'b1; bresp = 2'b00;
                log_q.push_back('{1'b1, aw_addr_l, w_data_l, w_strb_l, cyc});
            end
            if (arready) arready = 1'b0;
            else if (arvalid && !ar_stall) begin
                arready = 1'b1; last_araddr = araddr;
            end
            if (rvalid) begin
                rvalid = 1'b0; rresp = 2'b00;
            end else if (rready) begin
                rvalid = 1'b1;
                if (last_araddr == 4'h8) rdata = (stat_q.size() > 0) ? stat_q.pop_front() : stat_default;
                else rdata = rx_byte;
                if (rresp_done < rresp_req) begin
                    rresp = 2'b10; rresp_done++;
                end else rresp = 2'b00;
                log_q.push_back('{1'b0, last_araddr, rdata, 4'h0, cyc});
            end
        end
    end

    initial rresp_done = 0;

    // handshake-shape monitor and TX byte source bookkeeping
    always @(negedge clk) begin
        #1;
        if (awvalid) aw_hi++;
        if (wvalid) w_hi++;
        if (bready && (awvalid || wvalid)) overlap++;
        if (tx_ready) begin
            txr_cnt++;
            if (!bvalid) txr_nob++;
            tx_sent++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic get_txn(input string tag, input bit skip_stat, output txn_t t);
        bit ok = 0;
        t = '{1'b0, 4'h0, 32'h0, 4'h0, 0};
        for (int i = 0; i < 600 && !ok; i++) begin
            @(negedge clk); #2;
            while (log_q.size() > 0 && !ok) begin
                t = log_q.pop_front();
                if (!(skip_stat && !t.we && t.addr == 4'h8)) ok = 1;
            end
        end
        check({tag, "_arrived"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #2;
    endtask

    initial begin
        txn_t t, t0;
        int   n_rx, n_stat, n_tx, s_aw, s_w, s_ov, s_txr;
        bit   ok;
        logic [3:0]  rr_addr[6];
        logic [31:0] rr_data[6];
        rst_n = 1'b0; interrupt = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
        wait_cycles(3);
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_arvalid", 32'(arvalid), 0);
        check("rst_wvalid_bready_rready", {29'h0, wvalid, bready, rready}, 0);
        check("rst_addr_wdata", {awaddr, araddr, wdata[23:0]}, 0);
        check("rst_rx", {23'h0, rx_valid, rx_data}, 0);
        check("rst_err_txready", {27'h0, err, tx_ready}, 0);

        // INIT: CTRL write, then first STAT read only after the poll interval
        rst_n = 1'b1;
        get_txn("init_wr", 1'b0, t0);
        check("init_wr_we_addr", {t0.we, t0.addr}, {1'b1, 4'hC});
        check("init_wr_data", t0.data, 32'h13);
        check("init_wr_strb", 32'(t0.strb), 32'hF);
        get_txn("first_stat", 1'b0, t);
        check("first_stat_addr", {t.we, t.addr}, {1'b0, 4'h8});
        check("poll_gap_in_range", 32'((t.cyc - t0.cyc >= P) && (t.cyc - t0.cyc <= P + 8)), 1);

        // single TX byte
        s_txr = txr_cnt;
        tx_base = 8'h5A; tx_reqs = tx_sent + 1;
        get_txn("tx", 1'b1, t);
        check("tx_addr", {t.we, t.addr}, {1'b1, 4'h4});
        check("tx_data", t.data, 32'h5A);
        wait_cycles(30);
        check("tx_ready_pulses", 32'(txr_cnt - s_txr), 1);
        check("tx_ready_with_bvalid", 32'(txr_nob), 0);
        n_tx = 0;
        while (log_q.size() > 0) begin t = log_q.pop_front(); if (t.we) n_tx++; end
        check("tx_no_extra_write", 32'(n_tx), 0);

        // RX and TX both pending: strict alternation starting with RX
        rx_ready = 1'b1; rx_byte = 32'h33; stat_default = 32'h01;
        tx_base = 8'h10 - 8'(tx_sent); tx_reqs = tx_sent + 3;
        rr_addr = '{4'h0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h4};
        rr_data = '{32'h33, 32'h10, 32'h33, 32'h11, 32'h33, 32'h12};
        for (int i = 0; i < 6; i++) begin
            get_txn($sformatf("rr%0d", i), 1'b1, t);
            check($sformatf("rr%0d_addr", i), 32'(t.addr), 32'(rr_addr[i]));
            check($sformatf("rr%0d_data", i), t.data, rr_data[i]);
        end
        stat_default = 32'h04;
        wait_cycles(40);
        log_q.delete();
        rx_ready = 1'b0;
        wait_cycles(2);
        check("rr_rx_drained", 32'(rx_valid), 0);

        // RX byte held while the consumer is not ready
        interrupt = 1'b1; stat_default = 32'h01; rx_byte = 32'h41;
        get_txn("rx1", 1'b1, t);
        check("rx1_addr", {t.we, t.addr}, {1'b0, 4'h0});
        wait_cycles(40);
        check("rx1_held", {23'h0, rx_valid, rx_data}, {23'h0, 1'b1, 8'h41});
        n_rx = 0; n_stat = 0;
        while (log_q.size() > 0) begin
            t = log_q.pop_front();
            if (!t.we && t.addr == 4'h0) n_rx++;
            if (!t.we && t.addr == 4'h8) n_stat++;
        end
        check("rx_blocked_no_read", 32'(n_rx), 0);
        check("rx_blocked_stat_polled", 32'(n_stat > 0), 1);
        rx_byte = 32'h42;
        @(negedge clk); rx_ready = 1'b1;
        @(negedge clk); rx_ready = 1'b0; #2;
        check("rx_taken", 32'(rx_valid), 0);
        get_txn("rx2", 1'b1, t);
        check("rx2_addr", {t.we, t.addr}, {1'b0, 4'h0});
        wait_cycles(2);
        check("rx2_data", {23'h0, rx_valid, rx_data}, {23'h0, 1'b1, 8'h42});
        interrupt = 1'b0; stat_default = 32'h04; rx_ready = 1'b1;
        wait_cycles(30);
        rx_ready = 1'b0; log_q.delete();

        // slow AW, immediate W
        aw_delay = 2; s_aw = aw_hi; s_w = w_hi; s_ov = overlap;
        tx_base = 8'h77 - 8'(tx_sent); tx_reqs = tx_sent + 1;
        get_txn("slow_aw", 1'b1, t);
        check("slow_aw_data", t.data, 32'h77);
        check("awvalid_cycles", 32'(aw_hi - s_aw), 3);
        check("wvalid_cycles", 32'(w_hi - s_w), 1);
        check("bready_after_both", 32'(overlap - s_ov), 0);
        aw_delay = 0;

        // response error and STAT error bits, sticky until cleared
        rresp_req = rresp_req + 1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); #2; ok = err[3]; end
        check("rresp_err", 32'(err), 32'h8);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #2;
        check("err_cleared", 32'(err), 0);
        stat_q.push_back(32'hA4);
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); #2; ok = (err != 4'h0); end
        check("stat_err_bits", 32'(err), 32'h5);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0; #2;
        check("err_cleared2", 32'(err), 0);

        // reset while a read address is outstanding
        ar_stall = 1'b1;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk); #2; ok = arvalid; end
        check("arvalid_stalled", 32'(ok), 1);
        rst_n = 1'b0; #1;
        check("async_rst_arvalid", 32'(arvalid), 0);
        check("async_rst_rx", {23'h0, rx_valid, rx_data}, 0);
        wait_cycles(2);
        ar_stall = 1'b0; log_q.delete();
        rst_n = 1'b1;
        get_txn("reinit", 1'b0, t);
        check("reinit_we_addr", {t.we, t.addr}, {1'b1, 4'hC});
        check("reinit_data", t.data, 32'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
